rpc_host: RTL and testbench
===========================

# rpc_host

Host-side bus master for the RPC front-end link: the initiator that `RPCinterface` answers on the shared `cmd`/`data`/`data_valid` bus. It takes one command at a time from a local valid/ready request port and executes it on the bus. Writes are driven as data plus a one-cycle strobe; reads turn the bus around and capture the device's strobed reply, with a timeout. Tri-state is expressed as split out/oe/in signals; the top level builds the `inout` pins (`oe ? out : 'bZ`).

## Interface
- `SETUP_CYC`, 2: cycles `cmd` (and write data) are driven before strobe/turnaround; legal 1..15.
- `TIMEOUT`, 1000: maximum cycles spent waiting for read reply; legal 1..65535.
- `RD_CMD`, 3'h3: command code treated as a read; all other non-zero codes are writes.

- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: host idle, request accepted when `req_valid & req_ready`.
- `req_cmd` in 3: command code; 0 is illegal (bus idle code).
- `req_wdata` in 16: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 16: read data (0 for writes/errors).
- `rsp_err` out 1: timeout or illegal command, qualified by `rsp_valid`.
- `bus_cmd` out 3: command bus, 0 when idle.
- `bus_data_out` out 16, `bus_data_oe` out 1: data bus drive.
- `bus_data_in` in 16: data bus sample.
- `bus_valid_out` out 1, `bus_valid_oe` out 1: data_valid drive.
- `bus_valid_in` in 1: data_valid sample.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, TURN, WAIT, DONE. All outputs registered.
- Reset: state IDLE; every output 0 (incl. `req_ready`); `req_ready`=1 from first cycle with `rst` low. Reset mid-transaction aborts immediately: oe's drop, `bus_cmd`=0, no `rsp_valid`.
- IDLE: `req_ready`=1, `bus_cmd`=0, both oe=0. Accept latches cmd/wdata; `req_ready` drops next cycle.
- Illegal (`req_cmd`=0): straight to DONE, no bus activity, `rsp_err`=1.
- Write: SETUP (`bus_cmd`=cmd, `bus_data_out`=wdata, `bus_data_oe`=1, `bus_valid_oe`=1, `bus_valid_out`=0) for SETUP_CYC cycles -> STROBE (`bus_valid_out`=1, one cycle) -> HOLD (`bus_valid_out`=0, data still driven, one cycle) -> DONE.
- Read: SETUP (`bus_cmd`=RD_CMD, `bus_data_oe`=0, `bus_valid_oe`=1, `bus_valid_out`=0) for SETUP_CYC cycles -> TURN (`bus_valid_oe`=0, one cycle) -> WAIT. In WAIT sample `bus_valid_in` each cycle; first high sample captures `bus_data_in` into `rsp_rdata` -> DONE. After TIMEOUT WAIT cycles without valid -> DONE with `rsp_err`=1, `rsp_rdata`=0. Valid on the final WAIT cycle wins over timeout.
- `bus_cmd` held through SETUP..WAIT/HOLD; 0 in DONE/IDLE. `bus_valid_in`/`bus_data_in` ignored outside WAIT.
- DONE: `rsp_valid`=1 for one cycle, all oe=0, `bus_cmd`=0; `req_ready`=1 in the same cycle (ready/rsp coincide), next state IDLE. A request accepted during DONE is taken as if in IDLE.
- Never drives data and data_valid while expecting device drive: oe's are 0 from TURN onward.
- Timeout counter 16 bits, cleared on WAIT entry.

## Timing
- Accept at edge k. Write: SETUP k+1..k+S, STROBE k+S+1, HOLD k+S+2, DONE k+S+3 (default: `rsp_valid` at k+5).
- Read: SETUP k+1..k+S, TURN k+S+1, WAIT from k+S+2; valid sampled at cycle w -> DONE w+1. Timeout: DONE at k+S+2+TIMEOUT.
- Illegal: DONE at k+1.
- Back-to-back throughput: write every S+3 cycles.

## Test plan
- Write cmd 1, wdata 0x1234, S=2 -> `bus_data_oe`=1 k+1..k+4, `bus_valid_out` high only k+3, `rsp_valid` k+5, `rsp_err`=0, `bus_cmd`=0 at k+5.
- Read cmd 3; device drives 0xBEEF with `bus_valid_in` pulse at k+8 -> `bus_data_oe`=0 throughout, `bus_valid_oe`=0 from k+3, `rsp_valid` k+9, `rsp_rdata`=0xBEEF.
- Read, no reply, TIMEOUT=10 -> `rsp_valid` at k+14, `rsp_err`=1, `rsp_rdata`=0; repeat with valid exactly at k+13 -> success 0xBEEF.
- Request cmd 0 -> `rsp_valid`,`rsp_err`=1 at k+1, `bus_cmd` stays 0, no oe.
- `rst` high at k+2 of a write -> next cycle all outputs 0, no `rsp_valid`; `req_ready`=1 first cycle after release; fresh write completes normally.
- `req_valid` held with writes 0x0001, 0x0002 -> second accepted in first DONE cycle, `rsp_valid` pulses 5 cycles apart, `bus_valid_in` noise outside WAIT ignored.

Source files
------------

// File: rtl/rpc_host.sv
// Host-side bus master for the RPC front-end link: runs one queued command at a
// time on the shared cmd/data/data_valid bus, with split out/oe/in tri-state signals.
module rpc_host #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned TIMEOUT   = 1000,
  parameter logic [2:0]  RD_CMD    = 3'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [2:0]  bus_cmd,
  output logic [15:0] bus_data_out,
  output logic        bus_data_oe,
  input  logic [15:0] bus_data_in,
  output logic        bus_valid_out,
  output logic        bus_valid_oe,
  input  logic        bus_valid_in,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready are
  // both high; req_ready is high in IDLE and in DONE, so rsp_valid and the next
  // accept can coincide.

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_TURN, S_WAIT, S_DONE
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] rdata_d;
  logic        err_d;
  logic        accept;
  logic        drv_data, bus_on;

  // Outputs are registered copies of values decoded from the next state.
  logic        req_ready_d, rsp_valid_d, bus_data_oe_d, bus_valid_oe_d, bus_valid_out_d;
  logic [2:0]  bus_cmd_d;
  logic [15:0] bus_data_out_d;

  assign accept    = req_valid & req_ready;
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = 16'h0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          cmd_d   = req_cmd;
          wdata_d = req_wdata;
          if (req_cmd == 3'h0) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_SETUP;
            cnt_d   = 16'd1;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = (cmd_q == RD_CMD) ? S_TURN : S_STROBE;
        else                     cnt_d   = cnt_q + 16'd1;
      end
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = S_DONE;
      S_TURN: begin
        state_d = S_WAIT;
        cnt_d   = 16'd0;
      end
      S_WAIT: begin
        // A reply on the last allowed cycle still counts as success.
        if (bus_valid_in) begin
          state_d = S_DONE;
          rdata_d = bus_data_in;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    drv_data = ((state_d == S_SETUP) && (cmd_d != RD_CMD)) ||
               (state_d == S_STROBE) || (state_d == S_HOLD);
    bus_on   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD) ||
               (state_d == S_TURN)  || (state_d == S_WAIT);

    req_ready_d     = (state_d == S_IDLE) || (state_d == S_DONE);
    rsp_valid_d     = (state_d == S_DONE);
    bus_cmd_d       = bus_on ? cmd_d : 3'h0;
    bus_data_oe_d   = drv_data;
    bus_data_out_d  = drv_data ? wdata_d : 16'h0;
    bus_valid_oe_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    bus_valid_out_d = (state_d == S_STROBE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_q         <= 3'h0;
      wdata_q       <= 16'h0;
      cnt_q         <= 16'h0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 16'h0;
      rsp_err       <= 1'b0;
      bus_cmd       <= 3'h0;
      bus_data_out  <= 16'h0;
      bus_data_oe   <= 1'b0;
      bus_valid_out <= 1'b0;
      bus_valid_oe  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      req_ready     <= req_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rdata_d;
      rsp_err       <= err_d;
      bus_cmd       <= bus_cmd_d;
      bus_data_out  <= bus_data_out_d;
      bus_data_oe   <= bus_data_oe_d;
      bus_valid_out <= bus_valid_out_d;
      bus_valid_oe  <= bus_valid_oe_d;
    end
  end

endmodule

// File: tb/tb_rpc_host.sv
// Bench for rpc_host: cycle-exact bus/handshake checks on directed transactions plus
// a response scoreboard fed by a short random command mix.
module tb_rpc_host;

  localparam int unsigned TO = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = 3'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  bus_cmd;
  logic [15:0] bus_data_out;
  logic        bus_data_oe;
  logic [15:0] bus_data_in = 16'h0;
  logic        bus_valid_out;
  logic        bus_valid_oe;
  logic        bus_valid_in = 1'b0;
  logic [2:0]  dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [16:0] exp_q[$];

  rpc_host #(.SETUP_CYC(2), .TIMEOUT(TO), .RD_CMD(3'h3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_cmd(bus_cmd), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .bus_data_in(bus_data_in), .bus_valid_out(bus_valid_out), .bus_valid_oe(bus_valid_oe),
    .bus_valid_in(bus_valid_in), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {bus_cmd, data_oe, valid_oe, valid_out, rsp_valid, req_ready}
  function automatic logic [7:0] pk(input logic [2:0] c, input logic doe, input logic voe,
                                    input logic vout, input logic rv, input logic rdy);
    return {c, doe, voe, vout, rv, rdy};
  endfunction

  logic [7:0] obs;
  assign obs = {bus_cmd, bus_data_oe, bus_valid_oe, bus_valid_out, rsp_valid, req_ready};

  // Scoreboard: every completion is compared against the oldest expected response.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_extra", 32'(exp_q.size()), 32'd1);
      else check("rsp", {15'h0, rsp_err, rsp_rdata}, {15'h0, exp_q.pop_front()});
    end
  end

  // ---------------- driver ----------------
  // Returns just after the accepting edge k; the next negedge samples cycle k+1.
  task automatic send(input logic [2:0] cmd, input logic [15:0] wd, input logic [16:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    exp_q.push_back(exp);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  c;
    logic [15:0] d;
    int          dly;
    logic        got;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {24'h0, obs}, 32'h0);
    check("reset_data", {16'h0, bus_data_out}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Write 0x1234: SETUP k+1..k+2, STROBE k+3, HOLD k+4, DONE k+5.
    send(3'h1, 16'h1234, {1'b0, 16'h0});
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("wr_vec", {24'h0, obs}, {24'h0, pk((j <= 4) ? 3'h1 : 3'h0, j <= 4, j <= 4,
                                                j == 3, j == 5, j >= 5)});
      check("wr_data", {16'h0, bus_data_out}, (j <= 4) ? 32'h1234 : 32'h0);
      bus_valid_in = 1'($urandom_range(0, 1));
    end
    bus_valid_in = 1'b0;

    // Read with device reply pulsed in cycle k+8.
    send(3'h3, 16'hAAAA, {1'b0, 16'hBEEF});
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      check("rd_vec", {24'h0, obs}, {24'h0, pk((j <= 8) ? 3'h3 : 3'h0, 1'b0, j <= 2,
                                                1'b0, j == 9, j >= 9)});
      bus_valid_in = (j == 8);
      bus_data_in  = (j == 8) ? 16'hBEEF : 16'($urandom_range(0, 65535));
    end
    bus_valid_in = 1'b0;

    // Read timeout, then a reply exactly on the last WAIT cycle (k+13).
    for (int t = 0; t < 2; t++) begin
      send(3'h3, 16'h0, (t == 0) ? {1'b1, 16'h0} : {1'b0, 16'hBEEF});
      for (int j = 1; j <= 15; j++) begin
        @(negedge clk);
        check((t == 0) ? "to_vec" : "to_edge_vec", {24'h0, obs},
              {24'h0, pk((j <= 13) ? 3'h3 : 3'h0, 1'b0, j <= 2, 1'b0, j == 14, j >= 14)});
        bus_valid_in = (t == 1) && (j == 13);
        bus_data_in  = 16'hBEEF;
      end
      bus_valid_in = 1'b0;
    end

    // Illegal command 0: DONE at k+1, no bus activity.
    send(3'h0, 16'hFFFF, {1'b1, 16'h0});
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      check("ill_vec", {24'h0, obs}, {24'h0, pk(3'h0, 1'b0, 1'b0, 1'b0, j == 1, 1'b1)});
    end

    // Reset asserted during cycle k+2 of a write.
    send(3'h2, 16'h7777, {1'b0, 16'h0});
    @(negedge clk);
    @(negedge clk);
    check("rstw_k2", {24'h0, obs}, {24'h0, pk(3'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)});
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rstw_outs", {24'h0, obs}, 32'h0);
    check("rstw_data", {16'h0, bus_data_out}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstw_ready", 32'(req_ready), 32'd1);
    send(3'h2, 16'h5555, {1'b0, 16'h0});
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("post_rst_vec", {24'h0, obs}, {24'h0, pk((j <= 4) ? 3'h2 : 3'h0, j <= 4, j <= 4,
                                                      j == 3, j == 5, j >= 5)});
    end

    // Back-to-back writes with req_valid held; second accepted in first DONE.
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = 3'h1;
    req_wdata = 16'h0001;
    check("b2b_ready", 32'(req_ready), 32'd1);
    exp_q.push_back({1'b0, 16'h0});
    exp_q.push_back({1'b0, 16'h0});
    @(posedge clk);
    #1 req_wdata = 16'h0002;
    for (int j = 1; j <= 11; j++) begin
      logic act;
      @(negedge clk);
      act = (j <= 4) || (j >= 6 && j <= 9);
      check("b2b_vec", {24'h0, obs}, {24'h0, pk(act ? 3'h1 : 3'h0, act, act, j == 3 || j == 8,
                                                 j == 5 || j == 10, j == 5 || j >= 10)});
      check("b2b_data", {16'h0, bus_data_out},
            (j <= 4) ? 32'h1 : ((j >= 6 && j <= 9) ? 32'h2 : 32'h0));
      if (j == 6) req_valid = 1'b0;
      bus_valid_in = 1'($urandom_range(0, 1));
      bus_data_in  = 16'($urandom_range(0, 65535));
    end
    bus_valid_in = 1'b0;

    // Random mix: writes, illegal commands and reads with random reply delay.
    for (int i = 0; i < 12; i++) begin
      logic [16:0] e;
      c   = 3'($urandom_range(0, 7));
      d   = 16'($urandom_range(0, 65535));
      dly = $urandom_range(0, 12);
      if (c == 3'h0)      e = {1'b1, 16'h0};
      else if (c == 3'h3) e = (dly <= int'(TO) - 1) ? {1'b0, d} : {1'b1, 16'h0};
      else                e = {1'b0, 16'h0};
      send(c, d, e);
      got = 1'b0;
      for (int j = 1; j <= 40 && !got; j++) begin
        @(negedge clk);
        if (rsp_valid) got = 1'b1;
        bus_valid_in = (c == 3'h3) && (j == 4 + dly);
        bus_data_in  = (j == 4 + dly) ? d : 16'($urandom_range(0, 65535));
      end
      bus_valid_in = 1'b0;
      check("rnd_done", 32'(got), 32'd1);
    end

    repeat (3) @(negedge clk);
    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
